// File: rtl/poly1305_pkg.sv
// Shared constants and helpers for the Poly1305 block feeder.
package poly1305_pkg;

  // Feeder FSM encodings
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_AAD_IN   = 4'd1;
  localparam logic [3:0] ST_AAD_SEND = 4'd2;
  localparam logic [3:0] ST_AAD_WAIT = 4'd3;
  localparam logic [3:0] ST_PLD_IN   = 4'd4;
  localparam logic [3:0] ST_PLD_SEND = 4'd5;
  localparam logic [3:0] ST_PLD_WAIT = 4'd6;
  localparam logic [3:0] ST_LEN_SEND = 4'd7;
  localparam logic [3:0] ST_LEN_WAIT = 4'd8;
  localparam logic [3:0] ST_FIN      = 4'd9;

  // Segment codes carried on src_seg
  localparam logic SEG_AAD = 1'b0;
  localparam logic SEG_PLD = 1'b1;

  // A legal keep is a run of ones starting at bit 0 (zero included):
  // adding one then clears every set bit.
  function automatic logic keep_is_contig(input logic [15:0] keep);
    logic [15:0] k_plus_one;
    k_plus_one = keep + 16'd1;
    return ((keep & k_plus_one) == 16'd0);
  endfunction

  // Number of valid bytes in a beat
  function automatic logic [4:0] keep_popcount(input logic [15:0] keep);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, keep[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/poly1305_keep_mask.sv
// Combinational beat qualifier: keep legality, byte masking, byte count.
module poly1305_keep_mask
  import poly1305_pkg::*;
(
  input  logic [127:0] data_i,
  input  logic [15:0]  keep_i,
  output logic [127:0] data_o,
  output logic         valid_o,
  output logic [4:0]   count_o
);

  // Zero every byte lane whose keep bit is clear
  always_comb begin
    data_o = 128'd0;
    for (int i = 0; i < 16; i++) begin
      if (keep_i[i]) begin
        data_o[i*8 +: 8] = data_i[i*8 +: 8];
      end else begin
        data_o[i*8 +: 8] = 8'h00;
      end
    end
  end

  assign valid_o = keep_is_contig(keep_i);
  assign count_o = keep_popcount(keep_i);

endmodule

// File: rtl/poly1305_block_feeder.sv
// Slices an AAD + payload stream into 16-byte Poly1305 blocks, one at a
// time, then issues the little-endian length block and signals done.
module poly1305_block_feeder
  import poly1305_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  input  logic         src_valid,
  output logic         src_ready,
  input  logic [127:0] src_data,
  input  logic [15:0]  src_keep,
  input  logic         src_seg,
  input  logic         src_last,
  output logic         aad_valid,
  output logic         pld_valid,
  output logic         len_valid,
  input  logic         aad_ready,
  input  logic         pld_ready,
  input  logic         len_ready,
  output logic [127:0] blk_data,
  output logic [15:0]  blk_keep,
  input  logic         aad_done,
  input  logic         pld_done,
  input  logic         lens_done,
  output logic         mac_start,
  output logic         done,
  output logic         err,
  output logic [63:0]  aad_bytes,
  output logic [63:0]  pld_bytes
);

  logic [3:0]   state_q, state_d;
  logic [127:0] blk_data_q, blk_data_d;
  logic [15:0]  blk_keep_q, blk_keep_d;
  logic [63:0]  aad_bytes_q, aad_bytes_d;
  logic [63:0]  pld_bytes_q, pld_bytes_d;
  logic         last_q, last_d;
  logic         err_q, err_d;
  logic         mac_start_q, mac_start_d;
  logic         done_q;
  logic         busy_q;
  logic         src_ready_q;
  logic         aad_valid_q, pld_valid_q, len_valid_q;

  logic [127:0] masked_s;
  logic         keep_ok_s;
  logic [4:0]   keep_cnt_s;
  logic [63:0]  keep_cnt64_s;
  logic         beat_fire_s;

  poly1305_keep_mask u_keep_mask (
    .data_i  (src_data),
    .keep_i  (src_keep),
    .data_o  (masked_s),
    .valid_o (keep_ok_s),
    .count_o (keep_cnt_s)
  );

  assign keep_cnt64_s = {59'd0, keep_cnt_s};
  assign beat_fire_s  = src_valid && src_ready_q;

  // Next-state, block register and byte counter updates
  always_comb begin
    state_d     = state_q;
    blk_data_d  = blk_data_q;
    blk_keep_d  = blk_keep_q;
    aad_bytes_d = aad_bytes_q;
    pld_bytes_d = pld_bytes_q;
    last_d      = last_q;
    err_d       = 1'b0;
    mac_start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_AAD_IN;
          aad_bytes_d = 64'd0;
          pld_bytes_d = 64'd0;
          mac_start_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_AAD_IN: begin
        if (beat_fire_s) begin
          if (!keep_ok_s || (src_seg != SEG_AAD)) begin
            err_d = 1'b1;
          end else begin
            aad_bytes_d = aad_bytes_q + keep_cnt64_s;
            if (src_keep != 16'd0) begin
              blk_data_d = masked_s;
              blk_keep_d = src_keep;
              last_d     = src_last;
              state_d    = ST_AAD_SEND;
            end else if (src_last) begin
              state_d = ST_PLD_IN;
            end else begin
              state_d = ST_AAD_IN;
            end
          end
        end else begin
          state_d = ST_AAD_IN;
        end
      end
      ST_AAD_SEND: begin
        if (aad_ready) begin
          state_d = ST_AAD_WAIT;
        end else begin
          state_d = ST_AAD_SEND;
        end
      end
      ST_AAD_WAIT: begin
        if (aad_done) begin
          state_d = last_q ? ST_PLD_IN : ST_AAD_IN;
        end else begin
          state_d = ST_AAD_WAIT;
        end
      end
      ST_PLD_IN: begin
        if (beat_fire_s) begin
          if (!keep_ok_s || (src_seg != SEG_PLD)) begin
            err_d = 1'b1;
          end else begin
            pld_bytes_d = pld_bytes_q + keep_cnt64_s;
            if (src_keep != 16'd0) begin
              blk_data_d = masked_s;
              blk_keep_d = src_keep;
              last_d     = src_last;
              state_d    = ST_PLD_SEND;
            end else if (src_last) begin
              // Empty closing beat: counters are already final
              blk_data_d = {pld_bytes_q, aad_bytes_q};
              blk_keep_d = 16'hFFFF;
              state_d    = ST_LEN_SEND;
            end else begin
              state_d = ST_PLD_IN;
            end
          end
        end else begin
          state_d = ST_PLD_IN;
        end
      end
      ST_PLD_SEND: begin
        if (pld_ready) begin
          state_d = ST_PLD_WAIT;
        end else begin
          state_d = ST_PLD_SEND;
        end
      end
      ST_PLD_WAIT: begin
        if (pld_done) begin
          if (last_q) begin
            blk_data_d = {pld_bytes_q, aad_bytes_q};
            blk_keep_d = 16'hFFFF;
            state_d    = ST_LEN_SEND;
          end else begin
            state_d = ST_PLD_IN;
          end
        end else begin
          state_d = ST_PLD_WAIT;
        end
      end
      ST_LEN_SEND: begin
        if (len_ready) begin
          state_d = ST_LEN_WAIT;
        end else begin
          state_d = ST_LEN_SEND;
        end
      end
      ST_LEN_WAIT: begin
        if (lens_done) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_LEN_WAIT;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; outputs decoded from the next state so
  // every control output comes straight from a flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      blk_data_q  <= 128'd0;
      blk_keep_q  <= 16'd0;
      aad_bytes_q <= 64'd0;
      pld_bytes_q <= 64'd0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      mac_start_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      src_ready_q <= 1'b0;
      aad_valid_q <= 1'b0;
      pld_valid_q <= 1'b0;
      len_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_data_q  <= blk_data_d;
      blk_keep_q  <= blk_keep_d;
      aad_bytes_q <= aad_bytes_d;
      pld_bytes_q <= pld_bytes_d;
      last_q      <= last_d;
      err_q       <= err_d;
      mac_start_q <= mac_start_d;
      done_q      <= (state_d == ST_FIN);
      busy_q      <= (state_d != ST_IDLE);
      src_ready_q <= (state_d == ST_AAD_IN) || (state_d == ST_PLD_IN);
      aad_valid_q <= (state_d == ST_AAD_SEND);
      pld_valid_q <= (state_d == ST_PLD_SEND);
      len_valid_q <= (state_d == ST_LEN_SEND);
    end
  end

  assign busy      = busy_q;
  assign src_ready = src_ready_q;
  assign aad_valid = aad_valid_q;
  assign pld_valid = pld_valid_q;
  assign len_valid = len_valid_q;
  assign blk_data  = blk_data_q;
  assign blk_keep  = blk_keep_q;
  assign mac_start = mac_start_q;
  assign done      = done_q;
  assign err       = err_q;
  assign aad_bytes = aad_bytes_q;
  assign pld_bytes = pld_bytes_q;

endmodule

// File: tb/tb_poly1305_block_feeder.sv
// Directed scoreboard bench for poly1305_block_feeder.
module tb_poly1305_block_feeder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         busy;
  logic         src_valid = 1'b0;
  logic         src_ready;
  logic [127:0] src_data = 128'd0;
  logic [15:0]  src_keep = 16'd0;
  logic         src_seg = 1'b0;
  logic         src_last = 1'b0;
  logic         aad_valid, pld_valid, len_valid;
  logic         aad_ready = 1'b0, pld_ready = 1'b0, len_ready = 1'b0;
  logic [127:0] blk_data;
  logic [15:0]  blk_keep;
  logic         aad_done = 1'b0, pld_done = 1'b0, lens_done = 1'b0;
  logic         mac_start, done, err;
  logic [63:0]  aad_bytes, pld_bytes;

  localparam int K_AAD  = 0;
  localparam int K_PLD  = 1;
  localparam int K_LEN  = 2;
  localparam int K_NONE = 3;

  typedef struct {
    int           kind;
    logic [127:0] data;
    logic [15:0]  keep;
  } blk_t;

  blk_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  poly1305_block_feeder dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .src_keep(src_keep), .src_seg(src_seg), .src_last(src_last),
    .aad_valid(aad_valid), .pld_valid(pld_valid), .len_valid(len_valid),
    .aad_ready(aad_ready), .pld_ready(pld_ready), .len_ready(len_ready),
    .blk_data(blk_data), .blk_keep(blk_keep),
    .aad_done(aad_done), .pld_done(pld_done), .lens_done(lens_done),
    .mac_start(mac_start), .done(done), .err(err),
    .aad_bytes(aad_bytes), .pld_bytes(pld_bytes)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mask_bytes(input logic [127:0] d, input logic [15:0] k);
    logic [127:0] r;
    r = 128'd0;
    for (int i = 0; i < 16; i++) begin
      if (k[i]) r[i*8 +: 8] = d[i*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic valid_of(input int kind);
    case (kind)
      K_AAD:   return aad_valid;
      K_PLD:   return pld_valid;
      default: return len_valid;
    endcase
  endfunction

  function automatic logic [2:0] onehot_of(input int kind);
    case (kind)
      K_AAD:   return 3'b100;
      K_PLD:   return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  task automatic do_start(input string tag);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "_mac_start"}, {127'd0, mac_start}, 128'd1);
    check({tag, "_busy"}, {127'd0, busy}, 128'd1);
    check({tag, "_src_ready"}, {127'd0, src_ready}, 128'd1);
    check({tag, "_aad_clr"}, {64'd0, aad_bytes}, 128'd0);
    check({tag, "_pld_clr"}, {64'd0, pld_bytes}, 128'd0);
    @(negedge clk);
    check({tag, "_mac_start_pulse"}, {127'd0, mac_start}, 128'd0);
  endtask

  task automatic send_beat(input string tag, input logic [127:0] d, input logic [15:0] k,
                           input logic seg, input logic last, input int kind);
    blk_t b;
    int t = 0;
    while (src_ready !== 1'b1 && t < 50) begin
      @(negedge clk); t++;
    end
    check({tag, "_wait_ready"}, {127'd0, src_ready}, 128'd1);
    src_valid = 1'b1; src_data = d; src_keep = k; src_seg = seg; src_last = last;
    if (kind != K_NONE) begin
      b.kind = kind; b.data = mask_bytes(d, k); b.keep = k;
      exp_q.push_back(b);
    end
    @(negedge clk);
    src_valid = 1'b0; src_data = 128'd0; src_keep = 16'd0; src_last = 1'b0;
  endtask

  task automatic push_len(input logic [63:0] pld_n, input logic [63:0] aad_n);
    blk_t b;
    b.kind = K_LEN; b.data = {pld_n, aad_n}; b.keep = 16'hFFFF;
    exp_q.push_back(b);
  endtask

  task automatic serve(input string tag, input int kind, input int hold, input bit give_done);
    blk_t b;
    int t = 0;
    while (valid_of(kind) !== 1'b1 && t < 50) begin
      @(negedge clk); t++;
    end
    check({tag, "_wait_valid"}, {127'd0, valid_of(kind)}, 128'd1);
    if (exp_q.size() == 0) begin
      n_cmp++; n_mis++;
      $error("FAIL %s_sb: observed block expected none", tag);
      return;
    end
    b = exp_q.pop_front();
    check({tag, "_data"}, blk_data, b.data);
    check({tag, "_keep"}, {112'd0, blk_keep}, {112'd0, b.keep});
    check({tag, "_onehot"}, {125'd0, aad_valid, pld_valid, len_valid}, {125'd0, onehot_of(kind)});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {127'd0, valid_of(kind)}, 128'd1);
      check({tag, "_hold_data"}, blk_data, b.data);
      check({tag, "_hold_src_ready"}, {127'd0, src_ready}, 128'd0);
    end
    case (kind)
      K_AAD:   aad_ready = 1'b1;
      K_PLD:   pld_ready = 1'b1;
      default: len_ready = 1'b1;
    endcase
    @(negedge clk);
    aad_ready = 1'b0; pld_ready = 1'b0; len_ready = 1'b0;
    check({tag, "_valid_drop"}, {127'd0, valid_of(kind)}, 128'd0);
    @(negedge clk);
    check({tag, "_wait_src_ready"}, {127'd0, src_ready}, 128'd0);
    if (give_done) begin
      case (kind)
        K_AAD:   aad_done = 1'b1;
        K_PLD:   pld_done = 1'b1;
        default: lens_done = 1'b1;
      endcase
      @(negedge clk);
      aad_done = 1'b0; pld_done = 1'b0; lens_done = 1'b0;
    end
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done"}, {126'd0, done, busy}, {126'd0, 2'b11});
    @(negedge clk);
    check({tag, "_done_pulse"}, {126'd0, done, busy}, 128'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outs", {121'd0, busy, src_ready, aad_valid, pld_valid, len_valid, done, err}, 128'd0);
    check("rst_blk", blk_data, 128'd0);
    check("rst_cnt", {aad_bytes, pld_bytes}, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic message: 12 B AAD, 16 B payload
    do_start("m1");
    send_beat("m1_aad", 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'h0FFF, 1'b0, 1'b1, K_AAD);
    serve("m1_aad", K_AAD, 0, 1'b1);
    check("m1_ready_after_done", {127'd0, src_ready}, 128'd1);
    send_beat("m1_pld", 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F, 16'hFFFF, 1'b1, 1'b1, K_PLD);
    serve("m1_pld", K_PLD, 0, 1'b1);
    push_len(64'd16, 64'd12);
    serve("m1_len", K_LEN, 0, 1'b1);
    check_done("m1");
    check("m1_counts", {aad_bytes, pld_bytes}, {64'd12, 64'd16});

    // Masking, backpressure, bad keep, seg mismatch
    do_start("m2");
    send_beat("m2_aad", {16{8'hAA}}, 16'h0007, 1'b0, 1'b0, K_NONE);
    begin
      blk_t b;
      b.kind = K_AAD; b.data = {104'd0, 24'hAAAAAA}; b.keep = 16'h0007;
      exp_q.push_back(b);
    end
    serve("m2_aad", K_AAD, 10, 1'b1);
    check("m2_ready_back", {127'd0, src_ready}, 128'd1);
    send_beat("m2_badkeep", {16{8'h55}}, 16'h00F0, 1'b0, 1'b0, K_NONE);
    check("m2_err", {125'd0, err, aad_valid, src_ready}, {125'd0, 3'b101});
    check("m2_cnt_hold", {64'd0, aad_bytes}, 128'd3);
    @(negedge clk);
    check("m2_err_pulse", {127'd0, err}, 128'd0);
    send_beat("m2_aad_end", 128'd0, 16'h0000, 1'b0, 1'b1, K_NONE);
    check("m2_to_pld", {125'd0, aad_valid, src_ready, err}, {125'd0, 3'b010});
    send_beat("m2_segbad", {16{8'h11}}, 16'hFFFF, 1'b0, 1'b0, K_NONE);
    check("m2_seg_err", {125'd0, err, pld_valid, src_ready}, {125'd0, 3'b101});
    check("m2_pld_cnt", {64'd0, pld_bytes}, 128'd0);
    send_beat("m2_pld_end", 128'd0, 16'h0000, 1'b1, 1'b1, K_NONE);
    push_len(64'd0, 64'd3);
    serve("m2_len", K_LEN, 0, 1'b1);
    check_done("m2");

    // Empty AAD, 40-byte payload in three beats
    do_start("m3");
    send_beat("m3_aad", 128'd0, 16'h0000, 1'b0, 1'b1, K_NONE);
    check("m3_no_aad", {126'd0, aad_valid, src_ready}, {126'd0, 2'b01});
    for (int i = 0; i < 3; i++) begin
      logic [127:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      send_beat("m3_pld", d, (i == 2) ? 16'h00FF : 16'hFFFF, 1'b1, (i == 2), K_PLD);
      serve("m3_pld", K_PLD, i, 1'b1);
    end
    push_len(64'd40, 64'd0);
    serve("m3_len", K_LEN, 0, 1'b1);
    check_done("m3");

    // Reset in PLD_WAIT, then a clean message
    do_start("m4");
    send_beat("m4_aad", 128'd0, 16'h0000, 1'b0, 1'b1, K_NONE);
    send_beat("m4_pld", {16{8'h77}}, 16'hFFFF, 1'b1, 1'b0, K_PLD);
    serve("m4_pld", K_PLD, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("m4_rst_outs", {120'd0, busy, src_ready, aad_valid, pld_valid, len_valid, done, err, mac_start}, 128'd0);
    check("m4_rst_blk", blk_data, 128'd0);
    check("m4_rst_keep_cnt", {48'd0, blk_keep, pld_bytes}, 128'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("m4_quiet", {126'd0, done, err}, 128'd0);
    end
    do_start("m5");
    send_beat("m5_aad", 128'hDEADBEEF, 16'h000F, 1'b0, 1'b1, K_AAD);
    serve("m5_aad", K_AAD, 0, 1'b1);
    send_beat("m5_pld", 128'd0, 16'h0000, 1'b1, 1'b1, K_NONE);
    push_len(64'd0, 64'd4);
    serve("m5_len", K_LEN, 0, 1'b1);
    check_done("m5");
    check("sb_empty", exp_q.size(), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
